// File: rtl/spi_pkg.sv
// Shared types and helpers for the parametrised SPI master.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_t;

   // Bit positions inside the captured per-transfer mode word
   localparam int MODE_CPHA = 0;
   localparam int MODE_CPOL = 1;
   localparam int MODE_W    = 2;

   // Width of the slave-select index; never narrower than one bit
   function automatic int cs_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: one-cycle tick every CLK_DIV clocks while enabled.
module spi_clk_gen #(
   parameter int CLK_DIV = 24
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(CLK_DIV + 1);

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(CLK_DIV - 1));

   // Count half-period cycles; held at zero while disabled so each enable restarts the phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_mc.sv
// SPI master with per-transfer mode and slave select, valid/ready start, rx_valid pulse.
module spi_master_mc
   import spi_pkg::*;
#(
   parameter  int DATA_W  = 8,
   parameter  int CLK_DIV = 24,
   parameter  int NUM_CS  = 4,
   localparam int CS_W    = cs_width(NUM_CS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic [NUM_CS-1:0] ss_n
);

   localparam int EW = $clog2(2 * DATA_W + 1);

   spi_state_t        state, state_next;
   logic [DATA_W-1:0] tx_shift, tx_shift_next;
   logic [DATA_W-1:0] rx_shift, rx_shift_next;
   logic [DATA_W-1:0] rx_data_next;
   logic [MODE_W-1:0] mode, mode_next;
   logic [EW-1:0]     edge_cnt, edge_cnt_next;
   logic [NUM_CS-1:0] ss_n_next, ss_sel;
   logic              sclk_next, mosi_next, rx_valid_next;
   logic              tick, last_edge, sample_edge;

   spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
      .clk  (clk),
      .rst  (rst),
      .en   (state != IDLE),
      .tick (tick)
   );

   assign ready       = (state == IDLE);
   // edge_cnt holds edges already produced, so the upcoming edge is odd (leading) when it is even
   assign last_edge   = (edge_cnt == EW'(2 * DATA_W - 1));
   assign sample_edge = ~edge_cnt[0] ^ mode[MODE_CPHA];

   // Decode the requested select; an out-of-range index leaves every select high
   always_comb begin
      ss_sel = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (cs_sel == CS_W'(i)) ss_sel[i] = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   // Next-state: every phase change after IDLE happens on a half-period tick
   always_comb begin
      state_next = state;
      case (state)
         IDLE:        if (start) state_next = SETUP;
         SETUP, XFER: if (tick)  state_next = last_edge ? HOLD : XFER;
         HOLD:        if (tick)  state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   // Output and datapath next values; pins update on the same edge as the state
   always_comb begin
      sclk_next     = sclk;
      mosi_next     = mosi;
      ss_n_next     = ss_n;
      rx_data_next  = rx_data;
      rx_valid_next = 1'b0;
      tx_shift_next = tx_shift;
      rx_shift_next = rx_shift;
      mode_next     = mode;
      edge_cnt_next = edge_cnt;
      case (state)
         IDLE: begin
            sclk_next     = cpol;
            mosi_next     = 1'b0;
            ss_n_next     = '1;
            edge_cnt_next = '0;
            if (start) begin
               tx_shift_next            = tx_data;
               rx_shift_next            = '0;
               mode_next[MODE_CPOL]     = cpol;
               mode_next[MODE_CPHA]     = cpha;
               ss_n_next                = ss_sel;
               mosi_next                = ~cpha & tx_data[DATA_W-1];
            end
         end
         SETUP, XFER: begin
            if (tick) begin
               sclk_next     = ~sclk;
               edge_cnt_next = edge_cnt + 1'b1;
               if (sample_edge) begin
                  rx_shift_next = {rx_shift[DATA_W-2:0], miso};
               end else if (mode[MODE_CPHA]) begin
                  // Leading edge drives the bit at the top of the shifter
                  mosi_next     = tx_shift[DATA_W-1];
                  tx_shift_next = tx_shift << 1;
               end else if (!last_edge) begin
                  // MSB went out at SETUP, so the trailing edge presents the following bit
                  mosi_next     = tx_shift[DATA_W-2];
                  tx_shift_next = tx_shift << 1;
               end
            end
         end
         HOLD: begin
            sclk_next = mode[MODE_CPOL];
            if (tick) begin
               ss_n_next     = '1;
               mosi_next     = 1'b0;
               rx_data_next  = rx_shift;
               rx_valid_next = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Registered pins and datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         ss_n     <= '1;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         tx_shift <= '0;
         rx_shift <= '0;
         mode     <= '0;
         edge_cnt <= '0;
      end else begin
         sclk     <= sclk_next;
         mosi     <= mosi_next;
         ss_n     <= ss_n_next;
         rx_data  <= rx_data_next;
         rx_valid <= rx_valid_next;
         tx_shift <= tx_shift_next;
         rx_shift <= rx_shift_next;
         mode     <= mode_next;
         edge_cnt <= edge_cnt_next;
      end
   end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench: 8-bit/4-select master with a mode-matched slave, 16-bit master in loopback.
module tb_spi_master_mc;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   // Instance A: DATA_W=8, CLK_DIV=4, NUM_CS=4
   logic       start_a = 1'b0, cpol_a = 1'b0, cpha_a = 1'b0;
   logic [7:0] tx_a = '0;
   logic [1:0] cs_a = '0;
   logic       ready_a, rxv_a, sclk_a, mosi_a;
   logic       miso_a = 1'b0;
   logic [7:0] rx_a;
   logic [3:0] ss_n_a;

   // Instance B: DATA_W=16, CLK_DIV=1, NUM_CS=1, miso looped back from mosi
   logic        start_b = 1'b0, cpol_b = 1'b0, cpha_b = 1'b0;
   logic [15:0] tx_b = '0;
   logic [0:0]  cs_b = '0;
   logic        ready_b, rxv_b, sclk_b, mosi_b;
   wire         miso_b;
   logic [15:0] rx_b;
   logic [0:0]  ss_n_b;
   assign miso_b = mosi_b;

   int checks = 0;
   int passes = 0;

   spi_master_mc #(.DATA_W(8), .CLK_DIV(4), .NUM_CS(4)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .ready(ready_a), .tx_data(tx_a),
      .cs_sel(cs_a), .cpol(cpol_a), .cpha(cpha_a), .rx_data(rx_a), .rx_valid(rxv_a),
      .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .ss_n(ss_n_a)
   );

   spi_master_mc #(.DATA_W(16), .CLK_DIV(1), .NUM_CS(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .ready(ready_b), .tx_data(tx_b),
      .cs_sel(cs_b), .cpol(cpol_b), .cpha(cpha_b), .rx_data(rx_b), .rx_valid(rxv_b),
      .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .ss_n(ss_n_b)
   );

   // Slave model for instance A, following cpol_a/cpha_a
   logic [7:0] s_word = '0, s_shift = '0, s_rx = '0;
   logic       sclk_prev = 1'b0;
   logic [3:0] ss_prev = 4'hF;
   always @(sclk_a or ss_n_a) begin
      if (ss_n_a != ss_prev && ss_n_a != 4'hF) begin
         s_shift = s_word;
         s_rx    = '0;
         miso_a  = cpha_a ? 1'b0 : s_word[7];
      end else if (sclk_a != sclk_prev && ss_n_a != 4'hF) begin
         if ((sclk_a != cpol_a) ^ cpha_a) begin
            s_rx = {s_rx[6:0], mosi_a};
         end else if (cpha_a) begin
            miso_a  = s_shift[7];
            s_shift = s_shift << 1;
         end else begin
            s_shift = s_shift << 1;
            miso_a  = s_shift[7];
         end
      end
      ss_prev   = ss_n_a;
      sclk_prev = sclk_a;
   end

   task automatic next_cyc;
      @(posedge clk);
      #1;
   endtask

   // Accept edge is the posedge inside; returns #1 after it (cycle 1)
   task automatic launch_a(input logic [7:0] tx, input logic [1:0] cs);
      @(negedge clk);
      tx_a = tx; cs_a = cs; start_a = 1'b1;
      @(posedge clk);
      #1;
      start_a = 1'b0;
   endtask

   task automatic launch_b(input logic [15:0] tx, input logic [0:0] cs);
      @(negedge clk);
      tx_b = tx; cs_b = cs; start_b = 1'b1;
      @(posedge clk);
      #1;
      start_b = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) next_cyc();
      checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_a); else passes++;
      checks++; if (rxv_a !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rxv_a); else passes++;
      checks++; if (rx_a !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_a); else passes++;
      checks++; if (sclk_a !== 1'b0) $display("FAIL reset_sclk: got %b expected 0", sclk_a); else passes++;
      checks++; if (mosi_a !== 1'b0) $display("FAIL reset_mosi: got %b expected 0", mosi_a); else passes++;
      checks++; if (ss_n_a !== 4'hF) $display("FAIL reset_ss_n: got %h expected f", ss_n_a); else passes++;
      checks++; if (ss_n_b !== 1'b1) $display("FAIL reset_ss_n_b: got %b expected 1", ss_n_b); else passes++;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) next_cyc();
   endtask

   task automatic test_mode0;
      int vcyc = 0, ss_good = 0, ss_bad = 0;
      logic first_mosi;
      cpol_a = 1'b0; cpha_a = 1'b0; s_word = 8'h3C;
      repeat (2) next_cyc();
      launch_a(8'hA5, 2'd2);
      first_mosi = mosi_a;
      for (int cyc = 1; cyc <= 150 && vcyc == 0; cyc++) begin
         if (rxv_a) vcyc = cyc;
         else if (ss_n_a === 4'b1011) ss_good++;
         else ss_bad++;
         if (vcyc == 0) next_cyc();
      end
      $display("mode0 xfer: tx=a5 slave_rx=%h rx_data=%h rx_valid_cycle=%0d", s_rx, rx_a, vcyc);
      checks++; if (first_mosi !== 1'b1) $display("FAIL m0_setup_mosi: got %b expected 1", first_mosi); else passes++;
      checks++; if (vcyc != 69) $display("FAIL m0_valid_cycle: got %0d expected 69", vcyc); else passes++;
      checks++; if (rx_a !== 8'h3C) $display("FAIL m0_rx_data: got %h expected 3c", rx_a); else passes++;
      checks++; if (s_rx !== 8'hA5) $display("FAIL m0_mosi_bits: got %h expected a5", s_rx); else passes++;
      checks++; if (ss_good != 68 || ss_bad != 0) $display("FAIL m0_ss_low: got %0d good %0d bad expected 68 good 0 bad", ss_good, ss_bad); else passes++;
      checks++; if (ss_n_a !== 4'hF || ready_a !== 1'b1) $display("FAIL m0_end_state: got ss_n=%h ready=%b expected f 1", ss_n_a, ready_a); else passes++;
      next_cyc();
      checks++; if (rxv_a !== 1'b0 || rx_a !== 8'h3C) $display("FAIL m0_pulse_hold: got valid=%b data=%h expected 0 3c", rxv_a, rx_a); else passes++;
   endtask

   task automatic test_modes;
      logic [7:0] words [3];
      words[0] = 8'hC3; words[1] = 8'h69; words[2] = 8'h96;
      for (int m = 1; m <= 3; m++) begin
         logic [1:0] mb;
         logic [3:0] exp_ss;
         int vcyc, ss_bad;
         vcyc = 0; ss_bad = 0;
         mb = 2'(m);
         exp_ss = ~(4'b0001 << mb);
         cpol_a = mb[1]; cpha_a = mb[0]; s_word = words[m-1];
         repeat (3) next_cyc();
         checks++; if (sclk_a !== cpol_a) $display("FAIL mode%0d_idle_before: got %b expected %b", m, sclk_a, cpol_a); else passes++;
         launch_a(8'h5A, mb);
         for (int cyc = 1; cyc <= 150 && vcyc == 0; cyc++) begin
            if (rxv_a) vcyc = cyc;
            else if (ss_n_a !== exp_ss) ss_bad++;
            if (vcyc == 0) next_cyc();
         end
         $display("mode%0d xfer: tx=5a slave_rx=%h rx_data=%h rx_valid_cycle=%0d", m, s_rx, rx_a, vcyc);
         checks++; if (s_rx !== 8'h5A) $display("FAIL mode%0d_slave_rx: got %h expected 5a", m, s_rx); else passes++;
         checks++; if (rx_a !== words[m-1]) $display("FAIL mode%0d_rx_data: got %h expected %h", m, rx_a, words[m-1]); else passes++;
         checks++; if (vcyc != 69 || ss_bad != 0) $display("FAIL mode%0d_timing: got cycle %0d ss_bad %0d expected 69 0", m, vcyc, ss_bad); else passes++;
         repeat (2) next_cyc();
         checks++; if (sclk_a !== cpol_a) $display("FAIL mode%0d_idle_after: got %b expected %b", m, sclk_a, cpol_a); else passes++;
      end
   endtask

   task automatic test_start_ignored;
      int vcyc = 0, nv = 0, late_ss = 0;
      logic rdy10 = 1'b1;
      cpol_a = 1'b0; cpha_a = 1'b0; s_word = 8'h81;
      repeat (3) next_cyc();
      launch_a(8'h3C, 2'd0);
      for (int cyc = 1; cyc <= 100; cyc++) begin
         start_a = (cyc == 10 || cyc == 40);
         if (cyc == 10) rdy10 = ready_a;
         if (rxv_a) begin nv++; vcyc = cyc; end
         else if (vcyc != 0 && ss_n_a !== 4'hF) late_ss++;
         next_cyc();
      end
      start_a = 1'b0;
      $display("start_ignored xfer: rx_valid_count=%0d cycle=%0d rx_data=%h", nv, vcyc, rx_a);
      checks++; if (rdy10 !== 1'b0) $display("FAIL ign_ready_busy: got %b expected 0", rdy10); else passes++;
      checks++; if (nv != 1) $display("FAIL ign_valid_count: got %0d expected 1", nv); else passes++;
      checks++; if (vcyc != 69) $display("FAIL ign_valid_cycle: got %0d expected 69", vcyc); else passes++;
      checks++; if (rx_a !== 8'h81 || s_rx !== 8'h3C) $display("FAIL ign_data: got rx=%h slave=%h expected 81 3c", rx_a, s_rx); else passes++;
      checks++; if (late_ss != 0) $display("FAIL ign_no_restart: got %0d selected cycles expected 0", late_ss); else passes++;
   endtask

   task automatic test_back_to_back;
      int v1 = 0, v2 = 0, gap = 0;
      logic [7:0] rx1 = '0;
      logic [3:0] ss70 = '0;
      logic rdy70 = 1'b1;
      cpol_a = 1'b0; cpha_a = 1'b0; s_word = 8'h11;
      repeat (3) next_cyc();
      @(negedge clk);
      tx_a = 8'hE7; cs_a = 2'd1; start_a = 1'b1;
      @(posedge clk);
      #1;
      for (int cyc = 1; cyc <= 250 && v2 == 0; cyc++) begin
         if (rxv_a) begin
            if (v1 == 0) begin
               v1 = cyc; rx1 = rx_a; s_word = 8'h22; tx_a = 8'h18;
            end else begin
               v2 = cyc;
            end
         end
         if (v1 != 0 && v2 == 0 && ss_n_a === 4'hF) gap++;
         if (v1 != 0 && cyc == v1 + 1) begin
            ss70 = ss_n_a; rdy70 = ready_a; start_a = 1'b0;
         end
         if (v2 == 0) next_cyc();
      end
      start_a = 1'b0;
      $display("back_to_back xfer: v1=%0d rx1=%h v2=%0d rx2=%h gap=%0d", v1, rx1, v2, rx_a, gap);
      checks++; if (v1 != 69 || rx1 !== 8'h11) $display("FAIL b2b_first: got cycle %0d data %h expected 69 11", v1, rx1); else passes++;
      checks++; if (ss70 !== 4'b1101 || rdy70 !== 1'b0) $display("FAIL b2b_second_accept: got ss_n=%h ready=%b expected d 0", ss70, rdy70); else passes++;
      checks++; if (gap != 1) $display("FAIL b2b_gap: got %0d expected 1", gap); else passes++;
      checks++; if (v2 != 138) $display("FAIL b2b_second_cycle: got %0d expected 138", v2); else passes++;
      checks++; if (rx_a !== 8'h22 || s_rx !== 8'h18) $display("FAIL b2b_second_data: got rx=%h slave=%h expected 22 18", rx_a, s_rx); else passes++;
   endtask

   task automatic test_reset_mid;
      int nv = 0, vcyc = 0;
      cpol_a = 1'b0; cpha_a = 1'b0; s_word = 8'h5F;
      repeat (3) next_cyc();
      launch_a(8'hC6, 2'd3);
      repeat (28) next_cyc();
      checks++; if (sclk_a !== 1'b1) $display("FAIL rstmid_edge7_sclk: got %b expected 1", sclk_a); else passes++;
      rst = 1'b0;
      #1;
      $display("reset_mid: ready=%b ss_n=%h sclk=%b mosi=%b rx_valid=%b rx_data=%h", ready_a, ss_n_a, sclk_a, mosi_a, rxv_a, rx_a);
      checks++; if (ready_a !== 1'b1 || ss_n_a !== 4'hF) $display("FAIL rstmid_ready_ss: got %b %h expected 1 f", ready_a, ss_n_a); else passes++;
      checks++; if (sclk_a !== 1'b0 || mosi_a !== 1'b0) $display("FAIL rstmid_pins: got sclk=%b mosi=%b expected 0 0", sclk_a, mosi_a); else passes++;
      checks++; if (rxv_a !== 1'b0 || rx_a !== 8'h00) $display("FAIL rstmid_rx: got valid=%b data=%h expected 0 00", rxv_a, rx_a); else passes++;
      @(negedge clk);
      rst = 1'b1;
      for (int cyc = 0; cyc < 80; cyc++) begin
         next_cyc();
         if (rxv_a) nv++;
      end
      checks++; if (nv != 0) $display("FAIL rstmid_no_valid: got %0d pulses expected 0", nv); else passes++;
      s_word = 8'hB4;
      launch_a(8'h4D, 2'd3);
      for (int cyc = 1; cyc <= 150 && vcyc == 0; cyc++) begin
         if (rxv_a) vcyc = cyc;
         if (vcyc == 0) next_cyc();
      end
      $display("post_reset xfer: tx=4d slave_rx=%h rx_data=%h cycle=%0d", s_rx, rx_a, vcyc);
      checks++; if (vcyc != 69 || rx_a !== 8'hB4 || s_rx !== 8'h4D) $display("FAIL rstmid_recover: got cycle %0d rx %h slave %h expected 69 b4 4d", vcyc, rx_a, s_rx); else passes++;
   endtask

   task automatic test_loopback;
      int vcyc = 0, ss_low = 0;
      cpol_b = 1'b0; cpha_b = 1'b0;
      repeat (3) next_cyc();
      launch_b(16'h8001, 1'b0);
      for (int cyc = 1; cyc <= 100 && vcyc == 0; cyc++) begin
         if (rxv_b) vcyc = cyc;
         else if (ss_n_b === 1'b0) ss_low++;
         if (vcyc == 0) next_cyc();
      end
      $display("loopback mode0 xfer: tx=8001 rx_data=%h cycle=%0d ss_low=%0d", rx_b, vcyc, ss_low);
      checks++; if (vcyc != 34) $display("FAIL lb_valid_cycle: got %0d expected 34", vcyc); else passes++;
      checks++; if (rx_b !== 16'h8001) $display("FAIL lb_rx_data: got %h expected 8001", rx_b); else passes++;
      checks++; if (ss_low != 33) $display("FAIL lb_ss_low: got %0d expected 33", ss_low); else passes++;
      vcyc = 0; ss_low = 0;
      cpol_b = 1'b1; cpha_b = 1'b1;
      repeat (3) next_cyc();
      launch_b(16'h6C35, 1'b1);
      for (int cyc = 1; cyc <= 100 && vcyc == 0; cyc++) begin
         if (rxv_b) vcyc = cyc;
         else if (ss_n_b !== 1'b1) ss_low++;
         if (vcyc == 0) next_cyc();
      end
      $display("loopback mode3 bad-cs xfer: tx=6c35 rx_data=%h cycle=%0d ss_low=%0d", rx_b, vcyc, ss_low);
      checks++; if (ss_low != 0) $display("FAIL lb_badcs_ss: got %0d low cycles expected 0", ss_low); else passes++;
      checks++; if (vcyc != 34 || rx_b !== 16'h6C35) $display("FAIL lb_badcs_rx: got cycle %0d data %h expected 34 6c35", vcyc, rx_b); else passes++;
   endtask

   initial begin
      test_reset();
      test_mode0();
      test_modes();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      test_loopback();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
